// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter (send_en / send_data / tx_busy) between
//   NUM_REQ byte sources. Round-robin grant, one byte per grant. After a grant
//   the arbiter pulses send_en, waits for tx_busy to rise (bounded by
//   BUSY_TIMEOUT) and then for it to fall before the next grant.
//
// Parameters
//   NUM_REQ       number of requesters (2..8)
//   BUSY_TIMEOUT  max clk cycles waiting for tx_busy to rise after send_en (>=4)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester byte pending (data held until req_ready)
//   req_data     byte i at [8*i+7:8*i]
//   req_lock     (UART_TX_ARB_LOCK_EN only) keep the grant for the next byte
//   req_ready    one-cycle, one-hot accept pulse to the granted requester
//   tx_busy      transmitter busy (same clock domain)
//   send_en      one-cycle start pulse to the transmitter
//   send_data    byte to transmit, held until the next grant
//   grant_id     index of the last granted requester
//   arb_busy     high whenever the arbiter is not idle
//   timeout_err  one-cycle pulse: tx_busy never rose within BUSY_TIMEOUT
//
// Configuration macro
//   UART_TX_ARB_LOCK_EN  adds req_lock: a locked requester that still has a
//                        byte pending wins again without moving rr_ptr.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [8*NUM_REQ-1:0]         req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           req_lock,
`endif
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         tx_busy,
  output logic                         send_en,
  output logic [7:0]                   send_data,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         arb_busy,
  output logic                         timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [GW-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [TW-1:0]        tmo_cnt_reg, tmo_cnt_next;
  logic [NUM_REQ-1:0]   req_ready_reg, req_ready_next;
  logic                 send_en_reg, send_en_next;
  logic [7:0]           send_data_reg, send_data_next;
  logic [GW-1:0]        grant_id_reg, grant_id_next;
  logic                 timeout_err_reg, timeout_err_next;

  // Requester bytes as an array, and the round-robin scan order: entry k is
  // (rr_ptr + k) mod NUM_REQ, wrapped by explicit compare so non-power-of-two
  // requester counts work.
  logic [7:0]           req_byte [NUM_REQ];
  logic [GW-1:0]        scan_idx [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_scan
      logic [GW:0] sum;
      assign req_byte[gi] = req_data[8*gi +: 8];
      assign sum          = {1'b0, rr_ptr_reg} + (GW+1)'(gi);
      assign scan_idx[gi] = (sum >= (GW+1)'(NUM_REQ)) ? GW'(sum - (GW+1)'(NUM_REQ))
                                                      : sum[GW-1:0];
    end
  endgenerate

  // First valid requester in scan order (lowest k wins).
  logic          rr_found;
  logic [GW-1:0] rr_win;

  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[scan_idx[k]]) begin
        rr_found = 1'b1;
        rr_win   = scan_idx[k];
      end
    end
  end

  logic [GW-1:0] win;

`ifdef UART_TX_ARB_LOCK_EN
  // lock_ok remembers that the previous grant ended normally; a timeout
  // breaks the packet so round-robin resumes.
  logic lock_ok_reg, lock_ok_next;
  logic lock_win;
  assign lock_win = lock_ok_reg && req_lock[grant_id_reg] && req_valid[grant_id_reg];
  assign win      = lock_win ? grant_id_reg : rr_win;
`else
  assign win      = rr_win;
`endif

  // Next-state and output logic
  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    tmo_cnt_next     = tmo_cnt_reg;
    req_ready_next   = '0;
    send_en_next     = 1'b0;
    send_data_next   = send_data_reg;
    grant_id_next    = grant_id_reg;
    timeout_err_next = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    lock_ok_next     = lock_ok_reg;
`endif

    case (state_reg)
      IDLE: begin
        // A foreign frame on the transmitter blocks any grant.
        if (rr_found && !tx_busy) begin
          req_ready_next[win] = 1'b1;
          send_en_next        = 1'b1;
          send_data_next      = req_byte[win];
          grant_id_next       = win;
          rr_ptr_next         = (win == GW'(NUM_REQ - 1)) ? '0 : win + GW'(1);
`ifdef UART_TX_ARB_LOCK_EN
          if (lock_win) begin
            rr_ptr_next = rr_ptr_reg;
          end
          lock_ok_next = 1'b1;
`endif
          tmo_cnt_next        = '0;
          state_next          = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (tmo_cnt_reg == TW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never started: the byte is dropped.
          timeout_err_next = 1'b1;
          state_next       = IDLE;
`ifdef UART_TX_ARB_LOCK_EN
          lock_ok_next     = 1'b0;
`endif
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      tmo_cnt_reg     <= '0;
      req_ready_reg   <= '0;
      send_en_reg     <= 1'b0;
      send_data_reg   <= '0;
      grant_id_reg    <= '0;
      timeout_err_reg <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_ok_reg     <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      req_ready_reg   <= req_ready_next;
      send_en_reg     <= send_en_next;
      send_data_reg   <= send_data_next;
      grant_id_reg    <= grant_id_next;
      timeout_err_reg <= timeout_err_next;
`ifdef UART_TX_ARB_LOCK_EN
      lock_ok_reg     <= lock_ok_next;
`endif
    end
  end

  assign req_ready   = req_ready_reg;
  assign send_en     = send_en_reg;
  assign send_data   = send_data_reg;
  assign grant_id    = grant_id_reg;
  assign timeout_err = timeout_err_reg;
  assign arb_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NUM_REQ=4, BUSY_TIMEOUT=16).
//   Requesters are byte queues that pop on req_ready; a transmitter stub raises
//   tx_busy 3 clk after send_en for 10 clk. A transaction-level model predicts
//   every output each cycle; directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int BT = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N-1:0]   req_lock = '0;
`endif
  logic [N-1:0]   req_ready;
  logic           tx_busy;
  logic           send_en;
  logic [7:0]     send_data;
  logic [1:0]     grant_id;
  logic           arb_busy;
  logic           timeout_err;

  logic           stub_busy = 1'b0;
  logic           foreign_busy = 1'b0;
  bit             no_busy = 1'b0;
  int             busy_dly = 0;
  int             busy_len = 0;

  assign tx_busy = stub_busy | foreign_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .req_ready   (req_ready),
    .tx_busy     (tx_busy),
    .send_en     (send_en),
    .send_data   (send_data),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- requesters and transmitter stub ----------------
  logic [7:0] rq [N][$];
  logic [7:0] sent_log [$];

  task automatic refresh(input int i);
    req_valid[i] = (rq[i].size() > 0);
    if (rq[i].size() > 0) req_data[8*i +: 8] = rq[i][0];
  endtask

  task automatic push(input int i, input logic [7:0] b);
    rq[i].push_back(b);
    refresh(i);
  endtask

  always @(posedge clk) begin
    #1;
    if (busy_dly > 0) begin
      busy_dly--;
      if (busy_dly == 0) begin
        stub_busy = 1'b1;
        busy_len  = 10;
      end
    end else if (busy_len > 0) begin
      busy_len--;
      if (busy_len == 0) stub_busy = 1'b0;
    end
    if (send_en) begin
      sent_log.push_back(send_data);
      $display("grant: id=%0d data=%02h ready=%b", grant_id, send_data, req_ready);
      if (!no_busy) busy_dly = 3;
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && rq[i].size() > 0) begin
        void'(rq[i].pop_front());
        refresh(i);
      end
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit         m_active, m_saw, m_lock_ok;
  int         m_elapsed, m_rr;
  logic [3:0] e_ready;
  logic       e_send, e_tmo;
  logic [7:0] e_data;
  logic [1:0] e_gid;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_saw = 0; m_lock_ok = 0; m_elapsed = 0; m_rr = 0;
      e_ready = '0; e_send = 0; e_tmo = 0; e_data = '0; e_gid = '0;
    end
    chk("cyc_req_ready",   req_ready,   e_ready);
    chk("cyc_send_en",     send_en,     e_send);
    chk("cyc_send_data",   send_data,   e_data);
    chk("cyc_grant_id",    grant_id,    e_gid);
    chk("cyc_arb_busy",    arb_busy,    m_active);
    chk("cyc_timeout_err", timeout_err, e_tmo);
    if (rst_n) begin
      e_ready = '0; e_send = 0; e_tmo = 0;
      if (!m_active) begin
        if (req_valid != '0 && !tx_busy) begin
          int  w;
          bit  locked;
          w = -1;
          locked = 0;
`ifdef UART_TX_ARB_LOCK_EN
          if (m_lock_ok && req_lock[e_gid] && req_valid[e_gid]) begin
            w = int'(e_gid);
            locked = 1;
          end
`endif
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (w < 0 && req_valid[c]) w = c;
          end
          e_ready = 4'b0001 << w;
          e_send  = 1'b1;
          e_data  = req_data[8*w +: 8];
          e_gid   = 2'(w);
          if (!locked) m_rr = (w + 1) % N;
          m_active = 1; m_saw = 0; m_elapsed = 0; m_lock_ok = 1;
        end
      end else if (!m_saw) begin
        if (tx_busy) m_saw = 1;
        else begin
          m_elapsed++;
          if (m_elapsed == BT) begin
            e_tmo = 1'b1;
            m_active = 0;
            m_lock_ok = 0;
          end
        end
      end else if (!tx_busy) begin
        m_active = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_send(input string name);
    int n;
    n = 0;
    while (!send_en && n < 200) begin tick(); n++; end
    if (!send_en) chk({name, "_send_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((req_valid != '0 || arb_busy || tx_busy) && n < 1000) begin tick(); n++; end
    if (n >= 1000) chk({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] exp3 [5];
  logic [7:0] exp_lock [4];

  initial begin
    int n;
    int rdy_cnt;
    exp3     = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    exp_lock = '{8'hC0, 8'hC1, 8'hC2, 8'hD0};

    // Reset values
    tick(); tick();
    chk("rst_req_ready", req_ready, 32'd0);
    chk("rst_send_en",   send_en,   32'd0);
    chk("rst_send_data", send_data, 32'd0);
    chk("rst_grant_id",  grant_id,  32'd0);
    chk("rst_arb_busy",  arb_busy,  32'd0);
    chk("rst_timeout",   timeout_err, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single requester, one-clock latency
    push(0, 8'h55);
    tick();
    chk("single_send_en", send_en, 32'd1);
    chk("single_ready",   req_ready, 32'h1);
    chk("single_data",    send_data, 32'h55);
    wait_idle("single");
    chk("single_arb_idle", arb_busy, 32'd0);
    chk("single_data_held", send_data, 32'h55);

    // All four valid from rr_ptr=0: A0,A1,A2,A3,A0
    do_reset();
    sent_log.delete();
    push(0, 8'hA0); push(0, 8'hA0); push(1, 8'hA1); push(2, 8'hA2); push(3, 8'hA3);
    wait_idle("rr");
    chk("rr_count", sent_log.size(), 32'd5);
    for (int k = 0; k < 5; k++) chk($sformatf("rr_seq%0d", k), sent_log[k], exp3[k]);

    // Timeout: transmitter never starts (rr_ptr=1 now)
    sent_log.delete();
    no_busy = 1'b1;
    push(1, 8'h11); push(2, 8'h22);
    wait_send("tmo");
    n = 0;
    while (!timeout_err && n < 100) begin tick(); n++; end
    no_busy = 1'b0;
    chk("tmo_latency", n, BT);
    chk("tmo_arb_idle", arb_busy, 32'd0);
    tick();
    chk("tmo_next_ready", req_ready, 32'h4);
    wait_idle("tmo");
    chk("tmo_count", sent_log.size(), 32'd2);
    chk("tmo_seq0", sent_log[0], 32'h11);
    chk("tmo_seq1", sent_log[1], 32'h22);

    // Foreign frame blocks grants (rr_ptr=3)
    foreign_busy = 1'b1;
    push(1, 8'h33);
    rdy_cnt = 0;
    repeat (5) begin tick(); if (req_ready != '0) rdy_cnt++; end
    chk("foreign_no_ready", rdy_cnt, 32'd0);
    foreign_busy = 1'b0;
    tick();
    chk("foreign_send_en", send_en, 32'd1);
    chk("foreign_ready",   req_ready, 32'h2);
    chk("foreign_data",    send_data, 32'h33);
    wait_idle("foreign");

    // Reset mid-frame (rr_ptr=2): grant 3, abort, then 1 then 3 from index 0
    push(3, 8'h77); push(1, 8'h66);
    wait_send("midrst");
    chk("midrst_first_ready", req_ready, 32'h8);
    n = 0;
    while (!tx_busy && n < 50) begin tick(); n++; end
    tick(); tick();
    chk("midrst_in_frame", arb_busy, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 32'd0);
    chk("midrst_send_en", send_en, 32'd0);
    chk("midrst_data", send_data, 32'd0);
    chk("midrst_gid", grant_id, 32'd0);
    chk("midrst_arb_busy", arb_busy, 32'd0);
    chk("midrst_tmo", timeout_err, 32'd0);
    push(3, 8'h78);
    tick(); tick();
    sent_log.delete();
    rst_n = 1'b1;
    wait_idle("midrst");
    chk("midrst_count", sent_log.size(), 32'd2);
    chk("midrst_seq0", sent_log[0], 32'h66);
    chk("midrst_seq1", sent_log[1], 32'h78);

`ifdef UART_TX_ARB_LOCK_EN
    // Lock: requester 2 keeps the grant for its three bytes, then 0
    sent_log.delete();
    req_lock[2] = 1'b1;
    push(2, 8'hC0); push(2, 8'hC1); push(2, 8'hC2);
    wait_send("lock");
    push(0, 8'hD0);
    wait_idle("lock");
    req_lock[2] = 1'b0;
    chk("lock_count", sent_log.size(), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("lock_seq%0d", k), sent_log[k], exp_lock[k]);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
